// File: rtl/dqn_episode_sequencer_pkg.sv
// Shared constants for the DQN gridworld datapath: checker phase codes,
// action encodings and grid geometry.
package dqn_pkg;

    // Phase codes double as the sequencer state encoding and the checker's controller input.
    typedef enum logic [3:0] {
        PH_IDLE   = 4'd0,
        PH_COMMIT = 4'd1,
        PH_SELECT = 4'd2,
        PH_EP_END = 4'd3,
        PH_MOVE   = 4'd6,
        PH_UPDATE = 4'd7,
        PH_DONE   = 4'd8
    } phase_e;

    localparam logic [1:0] ACT_RIGHT = 2'd0;
    localparam logic [1:0] ACT_UP    = 2'd1;
    localparam logic [1:0] ACT_LEFT  = 2'd2;
    localparam logic [1:0] ACT_DOWN  = 2'd3;

    localparam int unsigned GRID_W      = 3;
    localparam logic [3:0]  STATE_START = 4'd1;

    function automatic logic phase_active(input phase_e p);
        return (p != PH_IDLE) && (p != PH_DONE);
    endfunction

endpackage

// File: rtl/dqn_episode_sequencer.sv
// Episode/step sequencer: drives checker phase codes and the Q-network
// select/update handshakes, tracks step and completed-episode counters.
module dqn_episode_sequencer
    import dqn_pkg::*;
#(
    parameter int unsigned MAX_STEP     = 14,
    parameter int unsigned GOAL_STATE   = 9,
    parameter int unsigned NUM_EPISODES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] st1,
    input  logic       q_ack,
    input  logic [1:0] q_act,
    input  logic       upd_ack,
    output logic       q_req,
    output logic       upd_req,
    output logic       term,
    output logic [1:0] act,
    output logic [3:0] step,
    output logic [3:0] controller,
    output logic [7:0] episode,
    output logic       env_clr,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] MAX_STEP_W = 4'(MAX_STEP);
    localparam logic [3:0] GOAL_W     = 4'(GOAL_STATE);
    localparam logic [7:0] NUM_EP_W   = 8'(NUM_EPISODES);

    phase_e     state_q, state_d;
    logic [3:0] step_q, step_d;
    logic [7:0] episode_q, episode_d;
    logic [1:0] act_q, act_d;
    logic       term_flag_q, term_flag_d;
    logic       abort_clr_q, abort_clr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= PH_IDLE;
            step_q      <= '0;
            episode_q   <= '0;
            act_q       <= ACT_RIGHT;
            term_flag_q <= 1'b0;
            abort_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            episode_q   <= episode_d;
            act_q       <= act_d;
            term_flag_q <= term_flag_d;
            abort_clr_q <= abort_clr_d;
        end
    end

    assign term = (state_q == PH_UPDATE) && ((st1 == GOAL_W) || (step_q == MAX_STEP_W));

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        episode_d   = episode_q;
        act_d       = act_q;
        term_flag_d = term_flag_q;
        abort_clr_d = 1'b0;

        // Abort pre-empts every phase handler, so coincident acks never land.
        if (abort && (state_q != PH_IDLE)) begin
            state_d     = PH_IDLE;
            step_d      = '0;
            episode_d   = '0;
            term_flag_d = 1'b0;
            abort_clr_d = 1'b1;
        end else begin
            unique case (state_q)
                PH_IDLE: begin
                    step_d    = '0;
                    episode_d = '0;
                    if (start && !abort) state_d = PH_EP_END;
                end
                PH_EP_END: begin
                    if (episode_q == NUM_EP_W) begin
                        state_d = PH_DONE;
                        step_d  = '0;
                    end else begin
                        state_d = PH_SELECT;
                        step_d  = 4'd1;
                    end
                end
                PH_SELECT: begin
                    if (q_ack) begin
                        act_d   = q_act;
                        state_d = PH_MOVE;
                    end
                end
                PH_MOVE: state_d = PH_UPDATE;
                PH_UPDATE: begin
                    if (upd_ack) begin
                        term_flag_d = term;
                        state_d     = PH_COMMIT;
                    end
                end
                PH_COMMIT: begin
                    if (term_flag_q) begin
                        state_d     = PH_EP_END;
                        episode_d   = episode_q + 8'd1;
                        term_flag_d = 1'b0;
                    end else begin
                        state_d = PH_SELECT;
                        if (step_q != MAX_STEP_W) step_d = step_q + 4'd1;
                    end
                end
                PH_DONE: begin
                    if (!start) begin
                        state_d   = PH_IDLE;
                        episode_d = '0;
                    end
                end
                default: state_d = PH_IDLE;
            endcase
        end
    end

    assign q_req      = (state_q == PH_SELECT);
    assign upd_req    = (state_q == PH_UPDATE);
    assign act        = act_q;
    assign step       = step_q;
    assign controller = state_q;
    assign episode    = episode_q;
    assign env_clr    = (state_q == PH_EP_END) || abort_clr_q;
    assign busy       = phase_active(state_q);
    assign done       = (state_q == PH_DONE);

endmodule

// File: doc/dqn_episode_sequencer.md
# dqn_episode_sequencer

- Drives the `step` and `controller` phase codes of the 3x3 gridworld environment checker.
- Runs the Q-network action-select and weight-update handshakes once per step.
- Decides episode termination (goal reached or step limit) and issues the environment clear between episodes.
- Sits between the top-level training controller (`start`/`abort`/`done`) and the checker plus Q-network datapath.

## Interface
Parameters:
- `MAX_STEP`, 14: last step index of an episode (1..15).
- `GOAL_STATE`, 9: grid state that terminates an episode.
- `NUM_EPISODES`, 16: episodes per training run (1..255).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; begins a run when sampled high in IDLE.
- `abort`  in  1  synchronous run cancel.
- `st1`  in  4  next-state from checker (valid from the first UPDATE cycle).
- `q_ack`  in  1  Q-network action valid; completes SELECT.
- `q_act`  in  2  action (0 right, 1 up, 2 left, 3 down); sampled with `q_ack`.
- `upd_ack`  in  1  Q-network update done; completes UPDATE.
- `q_req`  out  1  action request, high throughout SELECT.
- `upd_req`  out  1  update request, high throughout UPDATE.
- `term`  out  1  high in UPDATE when this transition ends the episode.
- `act`  out  2  latched action, to checker.
- `step`  out  4  current step, 0 when no episode is active.
- `controller`  out  4  phase code, to checker.
- `episode`  out  8  completed-episode count.
- `env_clr`  out  1  one-cycle environment clear pulse.
- `busy`  out  1  high in any state other than IDLE and DONE.
- `done`  out  1  run complete.

## Operation
- `controller` phase codes:
  - IDLE=0
  - COMMIT=1 (checker copies `st1` into `st`)
  - SELECT=2
  - EP_END=3
  - MOVE=6 (checker computes `st1` from `act`)
  - UPDATE=7
  - DONE=8
- Per-step order: SELECT -> MOVE -> UPDATE -> COMMIT.
- IDLE:
  - `step`=0.
  - `start`=1 -> EP_END: pulses `env_clr`, `episode` stays 0, then SELECT with `step`=1.
- SELECT:
  - `q_req`=1 until `q_ack`.
  - On `q_ack`, `act`<=`q_act` and go to MOVE.
  - `act` holds its value outside this capture.
- MOVE: one cycle, then UPDATE.
- UPDATE:
  - `upd_req`=1.
  - `term` = (`st1`==`GOAL_STATE`) or (`step`==`MAX_STEP`).
  - `term` is evaluated every cycle; the value on the `upd_ack` cycle is latched into an internal terminal flag.
  - `upd_ack` -> COMMIT.
- COMMIT: one cycle.
  - Flag clear -> `step`+1, go to SELECT.
  - Flag set -> EP_END.
- EP_END, entered from COMMIT:
  - `env_clr`=1 for one cycle and `episode`+1.
  - If the new `episode`==`NUM_EPISODES` -> DONE, `step`<=0.
  - Otherwise `step`<=1 -> SELECT.
- DONE:
  - `done`=1, `step`=0.
  - `start`=0 -> IDLE, which clears `episode` to 0 on entry.
  - `start` held high keeps the block in DONE; there is no automatic re-run.
- `abort`=1 in any non-IDLE state:
  - Next state IDLE, `step`<=0, `env_clr` pulses that cycle.
  - `episode` clears; no `done`.
  - An outstanding `q_ack`/`upd_ack` arriving in the same cycle is ignored.
- `abort` in IDLE: no effect, and it wins over `start`.
- Arithmetic:
  - `step` never exceeds `MAX_STEP`; no wrap.
  - `episode` is 8-bit and bounded by `NUM_EPISODES`.

## Timing
- Reset values, all outputs: `controller`=0 (IDLE), `step`=0, `act`=0, `episode`=0, and `q_req`, `upd_req`, `term`, `env_clr`, `busy`, `done` all 0.
- All outputs are registered or decoded from registered state only, with one exception: `term` is combinational from `st1`.
- Zero-stall step is 4 cycles (SELECT, MOVE, UPDATE, COMMIT) when `q_ack` and `upd_ack` arrive in the first cycle of their phase.
- Each ack-cycle stall adds one cycle.
- `q_ack` or `upd_ack` outside its phase is ignored.
- Start to first `q_req`: 2 cycles (IDLE sample, then EP_END).
- Reset asserted mid-run: immediate return to the reset values, with no `env_clr` pulse.

## Structure
- Shared package `dqn_pkg`:
  - controller phase code constants.
  - action encoding constants (`ACT_RIGHT`..`ACT_DOWN`).
  - grid constants (`GRID_W`=3, state start=1).
- The checker uses the same constants.
- Single module, one FSM plus step and episode counters; no sub-module.

## Test plan
- Reset: hold `rst`=0 -> all outputs at reset values; release -> `controller`=0, `busy`=0.
- Zero-stall step: `start`=1, `q_ack` immediate with `q_act`=0, `upd_ack` immediate -> `controller` sequence 3,2,6,7,1,2 and `step` 1->2 on the cycle after COMMIT.
- Stalled handshakes: delay `q_ack` 3 cycles with `q_act`=3, then `upd_ack` 2 cycles -> `q_req` high 4 cycles, `act`=3 from MOVE onward, `upd_req` high 3 cycles.
- Goal termination: `st1`=9 on step 4 -> `term`=1 in UPDATE, then COMMIT, EP_END with `env_clr` pulse, `episode` 0->1, next SELECT `step`=1.
- Step limit and run end: `NUM_EPISODES`=2, `st1` never 9 -> each episode ends at `step`=14, `done`=1 after the second EP_END, `start`=0 -> IDLE with `episode`=0.
- Abort mid-UPDATE with coincident `upd_ack` -> next cycle IDLE, `env_clr`=1 one cycle, `step`=0, `episode`=0, no COMMIT phase issued.
